// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way arbiter and its downstream transfer controller.
package arb_pkg;

    localparam int         NUM_REQ  = 4;
    localparam logic [2:0] GNT_NONE = 3'd4;

    typedef enum logic {IDLE, XFER} xfer_state_t;

    // Any grant code at or above GNT_NONE means "nobody granted".
    function automatic logic gnt_valid(input logic [2:0] gnt);
        return gnt < GNT_NONE;
    endfunction

endpackage

// File: rtl/arb_beat_cnt.sv
// Loadable down-counter tracking the beats remaining in the current burst.
module arb_beat_cnt #(
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [LENW-1:0] load_val,
    input  logic            dec,
    output logic [LENW-1:0] cnt,
    output logic            is_zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !is_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/arb_xfer_ctrl.sv
// Locks onto the arbiter's granted requester and streams its burst to one
// valid/ready output port, acknowledging each consumed beat back to the source.
module arb_xfer_ctrl
    import arb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      gnt_id,
    input  logic [DW-1:0]   data0,
    input  logic [DW-1:0]   data1,
    input  logic [DW-1:0]   data2,
    input  logic [DW-1:0]   data3,
    input  logic [LENW-1:0] len0,
    input  logic [LENW-1:0] len1,
    input  logic [LENW-1:0] len2,
    input  logic [LENW-1:0] len3,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_src,
    output logic            out_last,
    input  logic            out_ready,
    output logic            ack0,
    output logic            ack1,
    output logic            ack2,
    output logic            ack3,
    output logic            busy
);

    xfer_state_t          state;
    logic [1:0]           src;
    logic [LENW-1:0]      beats_left;
    logic                 is_zero;
    logic                 capture;
    logic                 fire;
    logic [LENW-1:0]      len_sel;
    logic [NUM_REQ-1:0]   ack_vec;

    assign capture = (state == IDLE) && gnt_valid(gnt_id);
    assign fire    = (state == XFER) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_valid(gnt_id)) begin
                        src   <= gnt_id[1:0];
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (out_ready && is_zero) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Length is picked by the incoming grant; it only reaches the counter's load port.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        len_sel  = len0;
        out_data = data0;
        case (gnt_id[1:0])
            2'd1:    len_sel = len1;
            2'd2:    len_sel = len2;
            2'd3:    len_sel = len3;
            default: len_sel = len0;
        endcase
        case (src)
            2'd1:    out_data = data1;
            2'd2:    out_data = data2;
            2'd3:    out_data = data3;
            default: out_data = data0;
        endcase
    end

    arb_beat_cnt #(
        .LENW (LENW)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (capture),
        .load_val (len_sel),
        .dec      (fire),
        .cnt      (beats_left),
        .is_zero  (is_zero)
    );

    assign out_valid = (state == XFER);
    assign busy      = (state != IDLE);
    assign out_src   = src;
    assign out_last  = (state == XFER) && (beats_left == '0);

    assign ack_vec = fire ? (NUM_REQ'(1) << src) : '0;
    assign ack0    = ack_vec[0];
    assign ack1    = ack_vec[1];
    assign ack2    = ack_vec[2];
    assign ack3    = ack_vec[3];

endmodule
